// File: rtl/mirfak_clint.sv
// mirfak_clint: core-local interruptor for the Mirfak CPU.
// Wishbone B4 classic slave holding mtime, mtimecmp and MSIP, and driving
// the machine timer / software interrupt lines.
// Build option: define MIRFAK_CLINT_EXT_TICK_EN to advance mtime from the
// asynchronous rtc_tick_i input instead of the internal TICK_DIV prescaler.
module mirfak_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
`ifdef MIRFAK_CLINT_EXT_TICK_EN
  ,
  input  logic        rtc_tick_i
`endif
);

  // Word offsets (byte offset >> 2) of the mapped registers.
  localparam logic [13:0] OFF_MSIP    = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
  localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
  localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        mtip_q, mtip_d;
  logic        msip_out_q, msip_out_d;
  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  logic        req_s;
  logic        hit_s;
  logic        mapped_s;
  logic        wr_s;
  logic [13:0] off_s;
  logic [31:0] rdata_s;
  logic        tick_s;
  logic        unused_addr_s;

  // Byte-offset bits [1:0] do not take part in decoding.
  assign unused_addr_s = ^wbs_addr_i[1:0];

  // Request qualification, address decode and read mux.
  always_comb begin
    req_s    = wbs_cyc_i & wbs_stb_i & ~(ack_q | err_q);
    off_s    = wbs_addr_i[15:2];
    mapped_s = 1'b0;
    rdata_s  = 32'h0000_0000;
    case (off_s)
      OFF_MSIP:    begin mapped_s = 1'b1; rdata_s = {31'h0000_0000, msip_q}; end
      OFF_CMP_LO:  begin mapped_s = 1'b1; rdata_s = mtimecmp_q[31:0];         end
      OFF_CMP_HI:  begin mapped_s = 1'b1; rdata_s = mtimecmp_q[63:32];        end
      OFF_TIME_LO: begin mapped_s = 1'b1; rdata_s = mtime_q[31:0];            end
      OFF_TIME_HI: begin mapped_s = 1'b1; rdata_s = mtime_q[63:32];           end
      default:     begin mapped_s = 1'b0; rdata_s = 32'h0000_0000;            end
    endcase
    hit_s = (wbs_addr_i[31:16] == BASE_ADDR[31:16]) & mapped_s;
    wr_s  = req_s & hit_s & wbs_we_i;
  end

  // One-cycle response; read data is captured with the response and held.
  always_comb begin
    ack_d = req_s & hit_s;
    err_d = req_s & ~hit_s;
    if (req_s) begin
      if (hit_s && !wbs_we_i) begin
        dat_d = rdata_s;
      end else begin
        dat_d = 32'h0000_0000;
      end
    end else begin
      dat_d = dat_q;
    end
  end

`ifdef MIRFAK_CLINT_EXT_TICK_EN
  logic [2:0] rtc_sync_q;

  // Two synchronizer stages plus an edge register on the external tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_sync_q <= 3'b000;
    end else begin
      rtc_sync_q <= {rtc_sync_q[1:0], rtc_tick_i};
    end
  end

  assign tick_s = rtc_sync_q[1] & ~rtc_sync_q[2];
`else
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  logic [15:0] presc_q, presc_d;

  // Prescaler counts 0..TICK_DIV-1; the wrap cycle is the tick.
  always_comb begin
    tick_s = (presc_q == PRESC_LAST);
    if (tick_s) begin
      presc_d = 16'h0000;
    end else begin
      presc_d = presc_q + 16'h0001;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 16'h0000;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  // Register writes and mtime advance; a write to mtime wins over a tick.
  always_comb begin
    if (wr_s && (off_s == OFF_MSIP) && wbs_sel_i[0]) begin
      msip_d = wbs_dat_i[0];
    end else begin
      msip_d = msip_q;
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_s && (off_s == OFF_CMP_LO)) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wbs_dat_i, wbs_sel_i);
    end else if (wr_s && (off_s == OFF_CMP_HI)) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
    end else begin
      mtimecmp_d = mtimecmp_q;
    end

    mtime_d = mtime_q;
    if (wr_s && (off_s == OFF_TIME_LO)) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wbs_dat_i, wbs_sel_i);
    end else if (wr_s && (off_s == OFF_TIME_HI)) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wbs_dat_i, wbs_sel_i);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end

    mtip_d     = (mtime_q >= mtimecmp_q);
    msip_out_d = msip_q;
  end

  // All bus, timer and interrupt state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'h0000_0000;
      mtip_q     <= 1'b0;
      msip_out_q <= 1'b0;
      msip_q     <= 1'b0;
      mtime_q    <= 64'h0000_0000_0000_0000;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      mtip_q     <= mtip_d;
      msip_out_q <= msip_out_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_dat_o   = dat_q;
  assign xint_mtip_o = mtip_q;
  assign xint_msip_o = msip_out_q;

endmodule

// File: doc/mirfak_clint.md
Name: mirfak_clint

Overview:
- Core-local interruptor (CLINT) for the Mirfak CPU.
- Wishbone B4 classic slave on the CPU data bus. Holds the 64-bit mtime counter, the 64-bit mtimecmp register and the MSIP bit.
- Produces the machine timer and software interrupt lines that feed mirfak_core's xint_mtip_i and xint_msip_i inputs.
- Sits beside the RAM on the data bus, behind the address decoder.

Parameters:
- BASE_ADDR, 32'h0200_0000: slave base. Only bits [31:16] are compared.
- TICK_DIV, 1: clk_i cycles per mtime increment. Legal range 1..65535. 1 means every cycle.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- wbs_addr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte enables
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_err_o  out  1  transfer error
- xint_mtip_o  out  1  machine timer interrupt pending
- xint_msip_o  out  1  machine software interrupt pending

Behaviour:
- Reset, asynchronous on rst_ni low:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0, xint_mtip_o = 0, xint_msip_o = 0.
- Register map. Offsets are wbs_addr_i[15:0]; bits [1:0] are ignored.
  - 0x0000 MSIP: bit0 is R/W, bits 31:1 read 0.
  - 0x4000 / 0x4004: MTIMECMP low / high word, R/W.
  - 0xBFF8 / 0xBFFC: MTIME low / high word, R/W.
- Handshake:
  - A request is cyc & stb with no ack/err issued in the previous cycle.
  - The response comes one cycle after the request: ack or err is high for exactly one cycle.
  - A master holding stb gets one response every second cycle. No back-to-back responses.
- Errors:
  - Address [31:16] different from BASE_ADDR[31:16], or an unmapped offset, produces err instead of ack.
  - An erroring write has no side effects. An erroring read returns wbs_dat_o = 0.
- Reads: wbs_dat_o is registered with the response and holds its value until the next response.
- Writes:
  - Applied at the request clock edge; byte lanes are gated by wbs_sel_i.
  - MSIP honours sel[0] only.
- Prescaler and counter:
  - The prescaler counts 0..TICK_DIV-1.
  - A tick is asserted when it wraps; mtime then increments by 1 with full 64-bit carry.
  - mtime wraps from all-ones to 0 silently.
- Write vs tick collision:
  - A write to either mtime half on a tick cycle suppresses that increment entirely.
  - The written bytes take the bus value; the other bytes keep their pre-tick value.
  - The prescaler continues unaffected.
- Interrupt outputs:
  - xint_mtip_o is registered as (mtime >= mtimecmp), unsigned 64-bit, evaluated on post-update values. It reflects a change one cycle after the update.
  - It stays asserted until software raises mtimecmp or lowers mtime.
  - xint_msip_o is a registered copy of msip; it rises one cycle after the write edge.
- No reset mid-transfer recovery is needed: reset clears any pending response immediately.

Optional Feature:
- Macro: MIRFAK_CLINT_EXT_TICK_EN.
- Defined:
  - Adds input port rtc_tick_i (1 bit, asynchronous).
  - rtc_tick_i passes through a 2-flop synchronizer plus an edge register; each rising edge produces one tick.
  - The internal prescaler and TICK_DIV are unused.
  - Tick latency is 3 clk_i cycles from the rising edge of rtc_tick_i.
- Undefined: no extra port; ticks come from the TICK_DIV prescaler only.

Test Plan:
- Reset, then read 0xBFF8 at cycle 10 with TICK_DIV=1 → ack one cycle later, data equals the cycle count since reset release. Read of 0x4004 → 32'hFFFF_FFFF. xint_mtip_o = 0.
- Write mtimecmp = 64'd50 (low word then high word = 0) → xint_mtip_o rises one cycle after mtime reaches 50. A subsequent write of mtimecmp high = 1 drops it next cycle.
- Write mtime low = 32'hFFFF_FFFF, high = 0 → after one tick, reads give low = 0 and high = 1 (carry check). Writing both halves = all-ones then one tick → both halves read 0.
- Write 0x0000 with dat = 1 and sel = 4'b0001 → xint_msip_o = 1. Same write with sel = 4'b0010 → no change. Write dat = 0 with sel = 4'b0001 → xint_msip_o = 0.
- Access 0x0200_0100, and separately 0x0300_0000 → wbs_err_o pulse with no ack, no state change. Holding stb for 6 cycles → exactly 3 responses.
- TICK_DIV=4: write mtime low on a tick cycle → read-back equals the written value, followed by +1 every 4 cycles. With MIRFAK_CLINT_EXT_TICK_EN, 5 rtc_tick_i pulses → mtime advances by exactly 5.
